// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor D = A - B - Bin, LSB first, using one full-subtractor cell.
// A start/busy/done handshake brackets each N-cycle operation.
module serial_subtractor #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         V
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [N-1:0]  ra, ra_nx, rb, rb_nx, res, res_nx, d_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          borrow, borrow_nx;
  logic          a_msb, a_msb_nx, b_msb, b_msb_nx;
  logic          busy_nx, done_nx, bout_nx, v_nx;
  logic          bit_a, bit_b, bit_d, bit_bo;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_nx  = state;
    ra_nx     = ra;
    rb_nx     = rb;
    res_nx    = res;
    cnt_nx    = cnt;
    borrow_nx = borrow;
    a_msb_nx  = a_msb;
    b_msb_nx  = b_msb;
    busy_nx   = 1'b0;
    done_nx   = 1'b0;
    d_nx      = D;
    bout_nx   = Bout;
    v_nx      = V;
    bit_a     = ra[0];
    bit_b     = rb[0];
    bit_d     = bit_a ^ bit_b ^ borrow;
    bit_bo    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx  = S_SHIFT;
          ra_nx     = A;
          rb_nx     = B;
          borrow_nx = Bin;
          a_msb_nx  = A[N-1];
          b_msb_nx  = B[N-1];
          cnt_nx    = '0;
          busy_nx   = 1'b1;
        end
      end
      S_SHIFT: begin
        borrow_nx = bit_bo;
        res_nx    = {bit_d, res[N-1:1]};
        ra_nx     = ra >> 1;
        rb_nx     = rb >> 1;
        cnt_nx    = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          // Last bit: publish the full result together with the done pulse
          state_nx = S_DONE;
          done_nx  = 1'b1;
          d_nx     = {bit_d, res[N-1:1]};
          bout_nx  = bit_bo;
          v_nx     = (a_msb ^ b_msb) & (bit_d ^ a_msb);
        end else begin
          busy_nx = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
    end else begin
      state  <= state_nx;
      ra     <= ra_nx;
      rb     <= rb_nx;
      res    <= res_nx;
      cnt    <= cnt_nx;
      borrow <= borrow_nx;
      a_msb  <= a_msb_nx;
      b_msb  <= b_msb_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      D      <= d_nx;
      Bout   <= bout_nx;
      V      <= v_nx;
    end
  end

endmodule
